counter_checker: RTL and testbench



---
 rtl/counter_checker_if.sv | 20 ++
 rtl/counter_checker.sv | 132 +++++++++++++
 tb/tb_counter_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/counter_checker_if.sv
// counter_checker_if: bundle between the counter pins and the counter checker.
//   c0..c7  : counter bits from the far end of the interconnect (c0 = LSB)
//   clear   : synchronous clear of err_cnt
//   locked  : checker is locked to the increment sequence
//   error   : one-cycle pulse per bad step while locked
//   err_cnt : 16-bit saturating count of error pulses
//   stall   : sticky stall flag (only active when STALL_CHECK_EN is defined)
// master drives the pins and clear; slave is the checker.
interface counter_checker_if;
    logic        c0, c1, c2, c3, c4, c5, c6, c7;
    logic        clear;
    logic        locked;
    logic        error;
    logic [15:0] err_cnt;
    logic        stall;
    modport master (output c0, c1, c2, c3, c4, c5, c6, c7, clear,
                    input  locked, error, err_cnt, stall);
    modport slave  (input  c0, c1, c2, c3, c4, c5, c6, c7, clear,
                    output locked, error, err_cnt, stall);
endinterface

// File: rtl/counter_checker.sv
// counter_checker: locks onto an 8-bit free-running counter pattern and flags sequence breaks.
// Ports:
//   clk     : clock, all logic on posedge
//   reset_n : synchronous active-low reset
//   bus     : counter_checker_if.slave (c0..c7, clear in; locked, error, err_cnt, stall out)
// Parameters:
//   LOCK_COUNT    : consecutive good steps needed to lock (1..15)
//   UNLOCK_ERRORS : consecutive bad steps while locked that force re-acquisition (1..15)
//   STALL_LIMIT   : max consecutive hold steps while locked (1..65535)
// Optional feature: define STALL_CHECK_EN to enable the stall detector; otherwise stall is 0
// and the value may hold indefinitely while locked.
module counter_checker #(
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_ERRORS = 2,
    parameter int STALL_LIMIT   = 255
) (
    input logic             clk,
    input logic             reset_n,
    counter_checker_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state, state_next;
    logic [7:0]  v, p;
    logic [3:0]  run, run_next, badrun, badrun_next;
    logic        hold, good, bad;
    logic        run_done, bad_done, stall_hit;
    logic        locked, error, error_next, stall, stall_next;
    logic [15:0] err_cnt, err_cnt_next;

    assign v    = {bus.c7, bus.c6, bus.c5, bus.c4, bus.c3, bus.c2, bus.c1, bus.c0};
    assign hold = v == p;
    // 8-bit add wraps, so 0xFF -> 0x00 classifies as good
    assign good = v == p + 8'd1;
    assign bad  = !hold && !good;

    assign run_done = ({1'b0, run} + 5'd1) == 5'(LOCK_COUNT);
    assign bad_done = ({1'b0, badrun} + 5'd1) == 5'(UNLOCK_ERRORS);

`ifdef STALL_CHECK_EN
    logic [15:0] hold_cnt, hold_cnt_next;
    assign stall_hit = state == LOCKED && hold && ({1'b0, hold_cnt} + 17'd1) == 17'(STALL_LIMIT);
    // counts only consecutive holds while locked; any step or leaving LOCKED restarts it
    assign hold_cnt_next = (state == LOCKED && hold && !stall_hit) ? hold_cnt + 16'd1 : 16'd0;
    always_ff @(posedge clk) begin
        if (!reset_n)
            hold_cnt <= 16'd0;
        else
            hold_cnt <= hold_cnt_next;
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= SEARCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        run_next    = run;
        badrun_next = badrun;
        case (state)
            SEARCH: begin
                state_next = ACQUIRE;
                run_next   = 4'd0;
            end
            ACQUIRE: begin
                if (good && run_done) begin
                    state_next  = LOCKED;
                    run_next    = 4'd0;
                    badrun_next = 4'd0;
                end else if (good) begin
                    run_next = run + 4'd1;
                end else if (bad) begin
                    run_next = 4'd0;
                end
            end
            LOCKED: begin
                if (good) begin
                    badrun_next = 4'd0;
                end else if (bad && bad_done) begin
                    state_next  = ACQUIRE;
                    run_next    = 4'd0;
                    badrun_next = 4'd0;
                end else if (bad) begin
                    badrun_next = badrun + 4'd1;
                end else if (stall_hit) begin
                    state_next = ACQUIRE;
                    run_next   = 4'd0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // clear takes priority over a same-edge increment; the error pulse itself is unaffected
    always_comb begin
        error_next   = state == LOCKED && bad;
        err_cnt_next = bus.clear ? 16'd0 :
                       (error_next && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
        stall_next   = stall || stall_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p       <= 8'd0;
            run     <= 4'd0;
            badrun  <= 4'd0;
            locked  <= 1'b0;
            error   <= 1'b0;
            err_cnt <= 16'd0;
            stall   <= 1'b0;
        end else begin
            p       <= v;
            run     <= run_next;
            badrun  <= badrun_next;
            locked  <= state_next == LOCKED;
            error   <= error_next;
            err_cnt <= err_cnt_next;
            stall   <= stall_next;
        end
    end

    assign bus.locked  = locked;
    assign bus.error   = error;
    assign bus.err_cnt = err_cnt;
    assign bus.stall   = stall;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed vector table plus saturation/stall sequences for counter_checker.
module tb_counter_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_m = 1'b0, rst_s = 1'b0, clr_m = 1'b0, clr_s = 1'b0;
    logic [7:0] v_m = 8'd0, v_s = 8'd0;

    counter_checker_if m_if();
    counter_checker_if s_if();

    assign {m_if.c7, m_if.c6, m_if.c5, m_if.c4, m_if.c3, m_if.c2, m_if.c1, m_if.c0} = v_m;
    assign {s_if.c7, s_if.c6, s_if.c5, s_if.c4, s_if.c3, s_if.c2, s_if.c1, s_if.c0} = v_s;
    assign m_if.clear = clr_m;
    assign s_if.clear = clr_s;

    counter_checker dut (.clk(clk), .reset_n(rst_m), .bus(m_if));
    counter_checker #(.UNLOCK_ERRORS(15)) dut_sat (.clk(clk), .reset_n(rst_s), .bus(s_if));

    typedef struct {
        logic        rst_n;
        logic        clr;
        logic [7:0]  v;
        logic        locked;
        logic        error;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic add(input logic r, input logic c, input logic [7:0] v,
                       input logic l, input logic e, input logic [15:0] n);
        vec_t t;
        t.rst_n = r; t.clr = c; t.v = v; t.locked = l; t.error = e; t.cnt = n;
        vq.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got locked=%0b error=%0b err_cnt=%h stall=%0b, expected locked=%0b error=%0b err_cnt=%h stall=%0b",
                     name, got[18], got[17], got[16:1], got[0], exp[18], exp[17], exp[16:1], exp[0]);
        end
    endtask

    function automatic logic [18:0] m_out();
        return {m_if.locked, m_if.error, m_if.err_cnt, m_if.stall};
    endfunction

    function automatic logic [18:0] s_out();
        return {s_if.locked, s_if.error, s_if.err_cnt, s_if.stall};
    endfunction

    initial begin
        int         exp_cnt;
        logic [7:0] x;
        // reset (clear ignored), then lock on 0x10..0x14
        add(0, 1, 8'h00, 0, 0, 16'h0000);
        add(0, 0, 8'h10, 0, 0, 16'h0000);
        add(1, 0, 8'h10, 0, 0, 16'h0000);
        add(1, 0, 8'h11, 0, 0, 16'h0000);
        add(1, 0, 8'h12, 0, 0, 16'h0000);
        add(1, 0, 8'h13, 0, 0, 16'h0000);
        add(1, 0, 8'h14, 1, 0, 16'h0000);
        // reset with clear while locked, relock at 0xFE, wrap is good
        add(0, 1, 8'hFA, 0, 0, 16'h0000);
        add(1, 0, 8'hFA, 0, 0, 16'h0000);
        add(1, 0, 8'hFB, 0, 0, 16'h0000);
        add(1, 0, 8'hFC, 0, 0, 16'h0000);
        add(1, 0, 8'hFD, 0, 0, 16'h0000);
        add(1, 0, 8'hFE, 1, 0, 16'h0000);
        add(1, 0, 8'hFF, 1, 0, 16'h0000);
        add(1, 0, 8'h00, 1, 0, 16'h0000);
        add(1, 0, 8'h01, 1, 0, 16'h0000);
        // each value held three cycles
        add(1, 0, 8'h01, 1, 0, 16'h0000);
        add(1, 0, 8'h01, 1, 0, 16'h0000);
        for (int k = 2; k <= 5; k++)
            for (int j = 0; j < 3; j++)
                add(1, 0, 8'(k), 1, 0, 16'h0000);
        add(1, 0, 8'h06, 1, 0, 16'h0000);
        // lock at 0x20, skips and unlock after two consecutive bad steps
        add(0, 0, 8'h1C, 0, 0, 16'h0000);
        add(1, 0, 8'h1C, 0, 0, 16'h0000);
        add(1, 0, 8'h1D, 0, 0, 16'h0000);
        add(1, 0, 8'h1E, 0, 0, 16'h0000);
        add(1, 0, 8'h1F, 0, 0, 16'h0000);
        add(1, 0, 8'h20, 1, 0, 16'h0000);
        add(1, 0, 8'h22, 1, 1, 16'h0001);
        add(1, 0, 8'h23, 1, 0, 16'h0001);
        add(1, 0, 8'h40, 1, 1, 16'h0002);
        add(1, 0, 8'h80, 0, 1, 16'h0003);
        // bad step while acquiring restarts the run and does not count
        add(1, 0, 8'h81, 0, 0, 16'h0003);
        add(1, 0, 8'h90, 0, 0, 16'h0003);
        add(1, 1, 8'h91, 0, 0, 16'h0000);
        add(1, 0, 8'h92, 0, 0, 16'h0000);
        add(1, 0, 8'h93, 0, 0, 16'h0000);
        add(1, 0, 8'h94, 1, 0, 16'h0000);
        // clear beats the increment, error still pulses
        add(1, 1, 8'hA0, 1, 1, 16'h0000);
        add(1, 0, 8'hA1, 1, 0, 16'h0000);
        add(1, 0, 8'hB0, 1, 1, 16'h0001);
        // reset aborts lock and zeroes the count; relock after 1 + LOCK_COUNT edges
        add(0, 0, 8'hB1, 0, 0, 16'h0000);
        add(1, 0, 8'hB1, 0, 0, 16'h0000);
        add(1, 0, 8'hB2, 0, 0, 16'h0000);
        add(1, 0, 8'hB3, 0, 0, 16'h0000);
        add(1, 0, 8'hB4, 0, 0, 16'h0000);
        add(1, 0, 8'hB5, 1, 0, 16'h0000);

        tick();
        foreach (vq[i]) begin
            rst_m = vq[i].rst_n;
            clr_m = vq[i].clr;
            v_m   = vq[i].v;
            tick();
            check($sformatf("vec%0d", i), m_out(), {vq[i].locked, vq[i].error, vq[i].cnt, 1'b0});
        end

        // long hold while locked
        clr_m = 1'b0;
        repeat (300) tick();
`ifdef STALL_CHECK_EN
        check("long_hold", m_out(), {1'b0, 1'b0, 16'h0000, 1'b1});
`else
        check("long_hold", m_out(), {1'b1, 1'b0, 16'h0000, 1'b0});
`endif

        // saturation on the UNLOCK_ERRORS = 15 instance
        rst_s = 1'b0;
        v_s   = 8'h00;
        tick();
        check("sat_reset", s_out(), {1'b0, 1'b0, 16'h0000, 1'b0});
        rst_s = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            v_s = 8'(k);
            tick();
        end
        check("sat_lock", s_out(), {1'b1, 1'b0, 16'h0000, 1'b0});
        x = 8'h04;
        exp_cnt = 0;
        for (int r = 0; r < 4682; r++) begin
            // 14 bad steps toggling bit 7, then one good step keeps the lock
            for (int i = 1; i <= 14; i++) begin
                v_s = (i % 2 == 1) ? (x ^ 8'h80) : x;
                tick();
            end
            x   = x + 8'd1;
            v_s = x;
            tick();
            exp_cnt = (exp_cnt + 14 > 65535) ? 65535 : exp_cnt + 14;
            if (r < 2 || r > 4678)
                check($sformatf("sat_round%0d", r), s_out(), {1'b1, 1'b0, 16'(exp_cnt), 1'b0});
        end
        v_s = x ^ 8'h80;
        tick();
        check("sat_hold_max", s_out(), {1'b1, 1'b1, 16'hFFFF, 1'b0});
        v_s   = x;
        clr_s = 1'b1;
        tick();
        check("sat_clear_bad", s_out(), {1'b1, 1'b1, 16'h0000, 1'b0});
        clr_s = 1'b0;
        v_s   = x ^ 8'h80;
        tick();
        check("sat_after_clear", s_out(), {1'b1, 1'b1, 16'h0001, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
